// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control FSM for the 8-bit datapath.
// Sequences fetch/decode/exec/mem/wb and drives the ALU control unit.
module alu_seq_ctrl #(
  parameter int CNT_W       = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       instr,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_op,
  output logic             alu_funct,
  output logic             alu_t0,
  output logic             alu_t1,
  output logic             alu_src_b,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [2:0]       state,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_HLT  = 3'b111;

  localparam int TO_W =
    (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);
  localparam bit TO_EN = (MEM_TIMEOUT != 0);

  logic [2:0]       state_q, state_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       opcode;
  logic             waiting;
  logic             to_hit;
  logic             unused_instr;

  assign opcode       = instr[7:5];
  assign unused_instr = ^instr[1:0];
  assign waiting      = (state_q == S_FETCH) || (state_q == S_MEM);
  assign to_hit       = TO_EN && waiting && !mem_ready
                        && (to_q == TO_MAX);

  always_comb begin
    state_d    = state_q;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    alu_op     = 3'b000;
    alu_funct  = 1'b0;
    alu_t0     = 1'b0;
    alu_t1     = 1'b0;
    alu_src_b  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_op    = 3'b001;
        alu_src_b = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          opcode == OP_JMP: begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
            state_d  = S_FETCH;
          end
          opcode == OP_HLT: state_d = S_HALT;
          default:          state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        unique case (1'b1)
          opcode == OP_R: begin
            alu_op    = 3'b000;
            alu_funct = instr[4];
            alu_t0    = instr[3];
            alu_t1    = instr[2];
            state_d   = S_WB;
          end
          opcode == OP_ADDI: begin
            alu_op    = 3'b001;
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          opcode == OP_LW || opcode == OP_SW: begin
            alu_op    = 3'b001;
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          opcode == OP_BEQ: begin
            alu_op   = 3'b010;
            pc_write = zero;
            pc_src   = 2'd1;
            state_d  = S_FETCH;
          end
          opcode == OP_SLT: begin
            alu_op  = 3'b011;
            state_d = S_WB;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_read  = (opcode == OP_LW);
        mem_write = (opcode == OP_SW);
        if (mem_ready)
          state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LW);
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_ERROR;
    endcase
    // A late mem_ready beats the timeout: to_hit needs mem_ready low.
    if (to_hit)
      state_d = S_ERROR;
  end

  always_comb begin
    to_d = to_q + TO_W'(1);
    if (!TO_EN || !waiting || mem_ready || state_d != state_q)
      to_d = '0;
  end

  assign cnt_d = cnt_q
    + CNT_W'(state_q == S_FETCH && mem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      to_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state       = state_q;
  assign halted      = (state_q == S_HALT) || (state_q == S_ERROR);
  assign error       = (state_q == S_ERROR);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: vector table plus
// hand sequences for reset, memory wait, timeout and wrap.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr;
  logic       mem_ready;
  logic       zero;

  logic       ir_write, pc_write, alu_funct, alu_t0, alu_t1;
  logic       alu_src_b, mem_read, mem_write, reg_write;
  logic       mem_to_reg, halted, error;
  logic [1:0] pc_src;
  logic [2:0] alu_op, state;
  logic [7:0] instr_count;

  logic       d2_ir_write, d2_pc_write, d2_alu_funct, d2_alu_t0;
  logic       d2_alu_t1, d2_alu_src_b, d2_mem_read, d2_mem_write;
  logic       d2_reg_write, d2_mem_to_reg, d2_halted, d2_error;
  logic [1:0] d2_pc_src;
  logic [2:0] d2_alu_op, d2_state;
  logic [1:0] d2_instr_count;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.CNT_W(8), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .mem_ready(mem_ready), .zero(zero),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_op(alu_op), .alu_funct(alu_funct), .alu_t0(alu_t0),
    .alu_t1(alu_t1), .alu_src_b(alu_src_b), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .state(state), .halted(halted),
    .error(error), .instr_count(instr_count)
  );

  alu_seq_ctrl #(.CNT_W(2), .MEM_TIMEOUT(15)) dut2 (
    .clk(clk), .reset(reset), .instr(instr),
    .mem_ready(mem_ready), .zero(zero),
    .ir_write(d2_ir_write), .pc_write(d2_pc_write),
    .pc_src(d2_pc_src), .alu_op(d2_alu_op),
    .alu_funct(d2_alu_funct), .alu_t0(d2_alu_t0),
    .alu_t1(d2_alu_t1), .alu_src_b(d2_alu_src_b),
    .mem_read(d2_mem_read), .mem_write(d2_mem_write),
    .reg_write(d2_reg_write), .mem_to_reg(d2_mem_to_reg),
    .state(d2_state), .halted(d2_halted), .error(d2_error),
    .instr_count(d2_instr_count)
  );

  typedef struct {
    logic [7:0]  instr;
    logic        mr;
    logic        z;
    logic [2:0]  st;
    logic [16:0] ctl;
    logic [7:0]  cnt;
  } vec_t;

  vec_t v[$];
  int checks = 0;
  int failures = 0;

  // {ir,pcw,src,op,fn/t0/t1,srcb,mrd,mwr,rw,m2r,halted,error}
  function automatic logic [16:0] ctl(
    input logic ir, input logic pcw, input logic [1:0] src,
    input logic [2:0] op, input logic [2:0] ftt,
    input logic sb, input logic mrd, input logic mwr,
    input logic rw, input logic m2r, input logic h,
    input logic e);
    return {ir, pcw, src, op, ftt, sb, mrd, mwr, rw, m2r, h, e};
  endfunction

  function automatic vec_t mk(
    input logic [7:0] i, input logic mr, input logic z,
    input logic [2:0] st, input logic [16:0] c,
    input logic [7:0] n);
    vec_t r;
    r.instr = i; r.mr = mr; r.z = z;
    r.st = st; r.ctl = c; r.cnt = n;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  logic [16:0] got;
  assign got = {ir_write, pc_write, pc_src, alu_op, alu_funct,
                alu_t0, alu_t1, alu_src_b, mem_read, mem_write,
                reg_write, mem_to_reg, halted, error};

  initial begin
    logic [16:0] F1, F0, Z, RW, EXI, MRD;
    F1  = ctl(1, 1, 0, 3'b001, 0, 1, 1, 0, 0, 0, 0, 0);
    F0  = ctl(0, 0, 0, 3'b001, 0, 1, 1, 0, 0, 0, 0, 0);
    Z   = '0;
    RW  = ctl(0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0, 0);
    EXI = ctl(0, 0, 0, 3'b001, 0, 1, 0, 0, 0, 0, 0, 0);
    MRD = ctl(0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0, 0);

    v.push_back(mk(8'h1C, 1, 0, 0, F1, 0));
    v.push_back(mk(8'h1C, 1, 0, 1, Z, 1));
    v.push_back(mk(8'h1C, 1, 0, 2,
      ctl(0, 0, 0, 3'b000, 3'b111, 0, 0, 0, 0, 0, 0, 0), 1));
    v.push_back(mk(8'h1C, 1, 0, 4, RW, 1));
    v.push_back(mk(8'h20, 1, 0, 0, F1, 1));
    v.push_back(mk(8'h20, 1, 0, 1, Z, 2));
    v.push_back(mk(8'h20, 1, 0, 2, EXI, 2));
    v.push_back(mk(8'h20, 1, 0, 4, RW, 2));
    v.push_back(mk(8'hA0, 1, 0, 0, F1, 2));
    v.push_back(mk(8'hA0, 1, 0, 1, Z, 3));
    v.push_back(mk(8'hA0, 1, 0, 2,
      ctl(0, 0, 0, 3'b011, 0, 0, 0, 0, 0, 0, 0, 0), 3));
    v.push_back(mk(8'hA0, 1, 0, 4, RW, 3));
    v.push_back(mk(8'h60, 1, 0, 0, F1, 3));
    v.push_back(mk(8'h60, 1, 0, 1, Z, 4));
    v.push_back(mk(8'h60, 1, 0, 2, EXI, 4));
    v.push_back(mk(8'h60, 1, 0, 3,
      ctl(0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0), 4));
    v.push_back(mk(8'h40, 1, 0, 0, F1, 4));
    v.push_back(mk(8'h40, 1, 0, 1, Z, 5));
    v.push_back(mk(8'h40, 1, 0, 2, EXI, 5));
    v.push_back(mk(8'h40, 0, 0, 3, MRD, 5));
    v.push_back(mk(8'h40, 0, 0, 3, MRD, 5));
    v.push_back(mk(8'h40, 0, 0, 3, MRD, 5));
    v.push_back(mk(8'h40, 1, 0, 3, MRD, 5));
    v.push_back(mk(8'h40, 1, 0, 4,
      ctl(0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1, 0, 0), 5));
    v.push_back(mk(8'h80, 1, 1, 0, F1, 5));
    v.push_back(mk(8'h80, 1, 1, 1, Z, 6));
    v.push_back(mk(8'h80, 1, 1, 2,
      ctl(0, 1, 1, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0), 6));
    v.push_back(mk(8'h80, 1, 0, 0, F1, 6));
    v.push_back(mk(8'h80, 1, 0, 1, Z, 7));
    v.push_back(mk(8'h80, 1, 0, 2,
      ctl(0, 0, 1, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0), 7));
    v.push_back(mk(8'hC0, 1, 0, 0, F1, 7));
    v.push_back(mk(8'hC0, 1, 0, 1,
      ctl(0, 1, 2, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0), 8));
    v.push_back(mk(8'h00, 0, 0, 0, F0, 8));

    reset = 1'b1;
    instr = '0;
    mem_ready = 1'b0;
    zero = 1'b0;
    tick();
    tick();
    chk("reset_state", 32'(state), 0);
    chk("reset_count", 32'(instr_count), 0);
    chk("reset_ctl", 32'(got), 32'(F0));
    reset = 1'b0;

    foreach (v[i]) begin
      instr = v[i].instr;
      mem_ready = v[i].mr;
      zero = v[i].z;
      #1;
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(v[i].st));
      chk($sformatf("vec%0d_ctl", i), 32'(got), 32'(v[i].ctl));
      chk($sformatf("vec%0d_cnt", i), 32'(instr_count),
          32'(v[i].cnt));
      tick();
    end

    // Async reset in the middle of an R-type EXEC
    instr = 8'h1C;
    mem_ready = 1'b1;
    tick();
    tick();
    chk("mid_exec_state", 32'(state), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_count", 32'(instr_count), 0);
    chk("async_rst_mrd", 32'(mem_read), 1);
    tick();
    reset = 1'b0;

    // Fetch timeout: 16 stalled cycles reach ERROR
    instr = 8'h00;
    mem_ready = 1'b0;
    pulse_reset();
    for (int k = 0; k < 15; k++) tick();
    chk("to_15_state", 32'(state), 0);
    tick();
    chk("to_16_state", 32'(state), 6);
    chk("to_halted", 32'(halted), 1);
    chk("to_error", 32'(error), 1);
    mem_ready = 1'b1;
    #1;
    chk("err_no_irw", 32'(ir_write), 0);
    chk("err_no_mrd", 32'(mem_read), 0);
    tick();
    tick();
    chk("err_absorb", 32'(state), 6);

    // mem_ready arriving on the timeout cycle wins
    mem_ready = 1'b0;
    pulse_reset();
    for (int k = 0; k < 15; k++) tick();
    mem_ready = 1'b1;
    #1;
    chk("tie_irw", 32'(ir_write), 1);
    tick();
    chk("tie_state", 32'(state), 1);
    chk("tie_error", 32'(error), 0);

    // 2-bit counter: four jumps then halt
    mem_ready = 1'b1;
    pulse_reset();
    for (int j = 0; j < 4; j++) begin
      instr = 8'hC0;
      tick();
      chk($sformatf("wrap_cnt%0d", j), 32'(d2_instr_count),
          32'((j + 1) % 4));
      chk($sformatf("wrap_dec%0d", j), 32'(d2_state), 1);
      tick();
    end
    instr = 8'hE0;
    tick();
    chk("halt_cnt", 32'(d2_instr_count), 1);
    tick();
    chk("halt_state", 32'(d2_state), 5);
    chk("halt_halted", 32'(d2_halted), 1);
    chk("halt_error", 32'(d2_error), 0);
    tick();
    chk("halt_absorb", 32'(d2_state), 5);
    chk("halt_cnt_hold", 32'(d2_instr_count), 1);
    chk("halt_no_mrd", 32'(d2_mem_read), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle control FSM for the 8-bit datapath.
- Sequences fetch/decode/execute/memory/writeback for each instruction.
- Drives the ALU control unit's inputs (ALUop, funct, t0, t1) and all datapath enables.
- Sits between the instruction register/memory interface and the ALU control unit plus register file.

Parameters:
- CNT_W, 8, width of retired-instruction counter
- MEM_TIMEOUT, 15, max consecutive cycles waiting on mem_ready before ERROR; 0 disables timeout

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- instr  input  8  IR contents: [7:5] opcode, [4] funct, [3] t0, [2] t1, [1:0] unused
- mem_ready  input  1  memory completes the current read/write this cycle
- zero  input  1  ALU zero flag, valid in EXEC
- ir_write  output  1  load IR from memory
- pc_write  output  1  load PC
- pc_src  output  2  0 = PC+1, 1 = branch target, 2 = jump target
- alu_op  output  3  to ALU control unit ALUop
- alu_funct  output  1  to ALU control unit funct
- alu_t0  output  1  to ALU control unit t0
- alu_t1  output  1  to ALU control unit t1
- alu_src_b  output  1  0 = register, 1 = immediate
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- reg_write  output  1  register file write enable
- mem_to_reg  output  1  writeback source, 1 = memory data
- state  output  3  current state code
- halted  output  1  in HALT or ERROR
- error  output  1  in ERROR
- instr_count  output  CNT_W  retired instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6.
- State, timeout counter and instr_count are registered. All other outputs are combinational from state, instr, zero and mem_ready. All outputs are 0 outside the conditions listed below.
- Reset (async, any time, including mid-instruction): state=FETCH, instr_count=0, timeout counter=0. Combinational outputs follow FETCH.
- FETCH:
  - mem_read=1, alu_op=001, alu_src_b=1, pc_src=0.
  - If mem_ready=1: ir_write=1, pc_write=1, next state DECODE, instr_count increments (wraps at 2^CNT_W).
  - Otherwise stay in FETCH.
- DECODE, by opcode:
  - 110 jump: pc_write=1, pc_src=2, next FETCH.
  - 111 halt: next HALT.
  - Any other opcode: next EXEC.
- EXEC:
  - 000 R-type: alu_op=000; alu_funct/alu_t0/alu_t1 = instr[4]/[3]/[2]; next WB.
  - 001 addi: alu_op=001, alu_src_b=1, next WB.
  - 010 lw, 011 sw: alu_op=001, alu_src_b=1, next MEM.
  - 100 beq: alu_op=010; pc_write=zero; pc_src=1; next FETCH.
  - 101 slt: alu_op=011, next WB.
  - alu_funct/t0/t1 are 0 for every non-R-type opcode.
- MEM:
  - lw: mem_read=1; if mem_ready, next WB.
  - sw: mem_write=1; if mem_ready, next FETCH.
  - Otherwise stay in MEM.
- WB: reg_write=1; mem_to_reg=1 only for lw; next FETCH.
- Latency (mem_ready immediate): jump 2, beq 3, R-type/addi/slt/sw 4, lw 5 cycles.
- Timeout:
  - Counter increments each cycle in FETCH or MEM with mem_ready=0.
  - Clears on mem_ready=1 or on any state change.
  - When the counter equals MEM_TIMEOUT and mem_ready=0, next state is ERROR.
  - With MEM_TIMEOUT=0 the block waits indefinitely.
- HALT and ERROR are absorbing until reset. halted=1 in both; error=1 only in ERROR. No enables are asserted in either state.
- Simultaneous mem_ready=1 with a timeout match: mem_ready wins and the normal transition is taken.

Test Plan:
- Reset mid-EXEC: assert reset at an arbitrary time -> state=0, instr_count=0, mem_read=1 in the same cycle, no clock edge needed.
- R-type: instr=8'b000_1_1_1_00, mem_ready=1 -> states 0,1,2,4,0; in EXEC alu_op=000, funct=1, t0=1, t1=1; reg_write=1 in WB; instr_count=1.
- lw with 3-cycle memory wait: instr=8'b010_00000, mem_ready low for 3 cycles in MEM -> stays in MEM 4 cycles, then WB with mem_to_reg=1, reg_write=1.
- beq: instr=8'b100_00000 with zero=1 -> pc_write=1, pc_src=1 in EXEC. Repeat with zero=0 -> pc_write=0. Both return to FETCH after 3 cycles.
- Timeout: MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> ERROR (state=6, halted=1, error=1) after 16 cycles. Raising mem_ready afterwards has no effect.
- Halt and counter wrap: CNT_W=2, run 4 jumps then a halt (8'b111_00000) -> instr_count sequence 1,2,3,0,1; state=5, halted=1, error=0.
